// File: rtl/core_if_ibuf_if.sv
// IF/ID fetch-queue bundle: upstream tuple, downstream head, flush and status.
interface core_if_ibuf_if #(
    parameter int DEPTH  = 4,
    parameter int INST_W = 32,
    parameter int PC_W   = 32
);
    localparam int CW = $clog2(DEPTH + 1);

    logic              valid_in;
    logic              ready_in;
    logic [INST_W-1:0] i_inst;
    logic [PC_W-1:0]   i_pc;
    logic              i_branch_predict;
    logic              valid_out;
    logic              ready_out;
    logic [INST_W-1:0] o_inst;
    logic [PC_W-1:0]   o_pc;
    logic              o_branch_predict;
    logic              i_pipe_flush_req;
    logic [CW-1:0]     o_count;
    logic              o_empty;
    logic              o_full;

    modport slave (
        input  valid_in, i_inst, i_pc, i_branch_predict,
        input  ready_out, i_pipe_flush_req,
        output ready_in, valid_out, o_inst, o_pc, o_branch_predict,
        output o_count, o_empty, o_full
    );

    modport master (
        output valid_in, i_inst, i_pc, i_branch_predict,
        output ready_out, i_pipe_flush_req,
        input  ready_in, valid_out, o_inst, o_pc, o_branch_predict,
        input  o_count, o_empty, o_full
    );
endinterface

// File: rtl/core_if_ibuf.sv
// DEPTH-entry instruction fetch queue between IFU and IDU.
// Optional empty-queue bypass; a flush empties the queue in one cycle.
module core_if_ibuf #(
    parameter int DEPTH  = 4,
    parameter int INST_W = 32,
    parameter int PC_W   = 32,
    parameter int BYPASS = 1
) (
    input logic           clk,
    input logic           rst,
    core_if_ibuf_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [DEPTH-1:0]  bp_mem;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic empty;
    logic full;
    logic flush;
    logic bypass;
    logic push;
    logic pop;
    logic pass;
    logic wr_en;
    logic rd_en;

    assign empty  = (count == '0);
    assign full   = (count == CW'(DEPTH));
    assign flush  = bus.i_pipe_flush_req;
    assign bypass = (BYPASS != 0) && empty;

    assign bus.ready_in  = !full;
    assign bus.valid_out = !flush && (bypass ? bus.valid_in : !empty);

    assign bus.o_inst           = bypass ? bus.i_inst : inst_mem[rd_ptr];
    assign bus.o_pc             = bypass ? bus.i_pc : pc_mem[rd_ptr];
    assign bus.o_branch_predict = bypass ? bus.i_branch_predict
                                         : bp_mem[rd_ptr];

    assign push = bus.valid_in && !full && !flush;
    assign pop  = bus.valid_out && bus.ready_out && !flush;

    // A tuple consumed in the same cycle it arrives on an empty queue
    // never touches storage.
    assign pass  = bypass && push && pop;
    assign wr_en = push && !pass;
    assign rd_en = pop && !pass;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(wr_en) - CW'(rd_en);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            inst_mem[wr_ptr] <= bus.i_inst;
            pc_mem[wr_ptr]   <= bus.i_pc;
            bp_mem[wr_ptr]   <= bus.i_branch_predict;
        end
    end

    assign bus.o_count = count;
    assign bus.o_empty = empty;
    assign bus.o_full  = full;

    a_no_overflow: assert property (
        @(posedge clk) disable iff (rst) count <= CW'(DEPTH));
    a_no_underflow: assert property (
        @(posedge clk) disable iff (rst) !(rd_en && empty));
    a_no_write_full: assert property (
        @(posedge clk) disable iff (rst) !(wr_en && full));
endmodule

// File: tb/tb_core_if_ibuf.sv
// Bench for core_if_ibuf: vector table, corner sequences and a random run
// against a queue model, with BYPASS=0 (dut0) and BYPASS=1 (dut1).
module tb_core_if_ibuf;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        bp;
    } tuple_t;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        ro;
        logic        fl;
        logic        vo;
        logic        ri;
        int          cnt;
        logic [31:0] opc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        v   = 1'b0;
    logic        ro  = 1'b0;
    logic        fl  = 1'b0;
    logic        bp  = 1'b0;
    logic [31:0] pc  = '0;
    logic [31:0] inst = '0;

    int total = 0;
    int bad   = 0;

    tuple_t q0[$];
    tuple_t q1[$];
    vec_t   tv[$];

    always #5 clk = ~clk;

    core_if_ibuf_if #(.DEPTH(DEPTH), .INST_W(32), .PC_W(32)) b0 ();
    core_if_ibuf_if #(.DEPTH(DEPTH), .INST_W(32), .PC_W(32)) b1 ();

    assign b0.valid_in         = v;
    assign b0.i_inst           = inst;
    assign b0.i_pc             = pc;
    assign b0.i_branch_predict = bp;
    assign b0.ready_out        = ro;
    assign b0.i_pipe_flush_req = fl;
    assign b1.valid_in         = v;
    assign b1.i_inst           = inst;
    assign b1.i_pc             = pc;
    assign b1.i_branch_predict = bp;
    assign b1.ready_out        = ro;
    assign b1.i_pipe_flush_req = fl;

    core_if_ibuf #(.DEPTH(DEPTH), .INST_W(32), .PC_W(32), .BYPASS(0)) dut0 (
        .clk(clk), .rst(rst), .bus(b0)
    );
    core_if_ibuf #(.DEPTH(DEPTH), .INST_W(32), .PC_W(32), .BYPASS(1)) dut1 (
        .clk(clk), .rst(rst), .bus(b1)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v_, input logic [31:0] pc_,
                                input logic ro_, input logic fl_,
                                input logic vo_, input logic ri_,
                                input int cnt_, input logic [31:0] opc_);
        vec_t r;
        r.v = v_; r.pc = pc_; r.ro = ro_; r.fl = fl_;
        r.vo = vo_; r.ri = ri_; r.cnt = cnt_; r.opc = opc_;
        return r;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        v = 1'b0; ro = 1'b0; fl = 1'b0; pc = '0; inst = '0; bp = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst d0 vo", 64'(b0.valid_out), 64'd0);
        chk("rst d0 empty", 64'(b0.o_empty), 64'd1);
        chk("rst d0 full", 64'(b0.o_full), 64'd0);
        chk("rst d0 cnt", 64'(b0.o_count), 64'd0);
        chk("rst d0 ri", 64'(b0.ready_in), 64'd1);
        chk("rst d1 vo", 64'(b1.valid_out), 64'd0);
        chk("rst d1 cnt", 64'(b1.o_count), 64'd0);
        rst = 1'b0;
        q0.delete();
        q1.delete();
    endtask

    // Model: a tuple queue; one call per DUT per cycle, before the edge.
    task automatic rstep(input int k, input int cyc);
        tuple_t q[$];
        tuple_t eo;
        tuple_t ao;
        int     n;
        logic   byp;
        logic   evo;
        logic   epop;
        logic   epush;
        logic   avo, ari, aemp, afull;
        logic [2:0] acnt;
        string  tag;
        tag = $sformatf("rnd d%0d c%0d", k, cyc);
        if (k == 0) begin
            q = q0; byp = 1'b0;
            avo = b0.valid_out; ari = b0.ready_in; aemp = b0.o_empty;
            afull = b0.o_full; acnt = b0.o_count;
            ao = '{b0.o_inst, b0.o_pc, b0.o_branch_predict};
        end else begin
            q = q1; byp = 1'b1;
            avo = b1.valid_out; ari = b1.ready_in; aemp = b1.o_empty;
            afull = b1.o_full; acnt = b1.o_count;
            ao = '{b1.o_inst, b1.o_pc, b1.o_branch_predict};
        end
        n  = q.size();
        eo = '{inst, pc, bp};
        if (fl) evo = 1'b0;
        else if (n > 0) begin evo = 1'b1; eo = q[0]; end
        else evo = byp && v;
        chk({tag, " vo"}, 64'(avo), 64'(evo));
        chk({tag, " ri"}, 64'(ari), 64'(n != DEPTH));
        chk({tag, " cnt"}, 64'(acnt), 64'(n));
        chk({tag, " empty"}, 64'(aemp), 64'(n == 0));
        chk({tag, " full"}, 64'(afull), 64'(n == DEPTH));
        if (evo) chk({tag, " out"}, 64'(ao), 64'(eo));
        if (fl) q.delete();
        else begin
            epop  = evo && ro;
            epush = v && (n != DEPTH);
            if (!(n == 0 && epop && epush)) begin
                if (epop) void'(q.pop_front());
                if (epush) q.push_back('{inst, pc, bp});
            end
        end
        if (k == 0) q0 = q; else q1 = q;
    endtask

    initial begin
        // fill / overflow / drain
        tv.push_back(mk(1, 32'h8000_0000, 0, 0, 0, 1, 0, 0));
        tv.push_back(mk(1, 32'h8000_0004, 0, 0, 1, 1, 1, 32'h8000_0000));
        tv.push_back(mk(1, 32'h8000_0008, 0, 0, 1, 1, 2, 32'h8000_0000));
        tv.push_back(mk(1, 32'h8000_000C, 0, 0, 1, 1, 3, 32'h8000_0000));
        tv.push_back(mk(1, 32'h8000_0010, 0, 0, 1, 0, 4, 32'h8000_0000));
        tv.push_back(mk(0, 32'h0, 0, 0, 1, 0, 4, 32'h8000_0000));
        tv.push_back(mk(0, 32'h0, 1, 0, 1, 0, 4, 32'h8000_0000));
        tv.push_back(mk(0, 32'h0, 1, 0, 1, 1, 3, 32'h8000_0004));
        tv.push_back(mk(0, 32'h0, 1, 0, 1, 1, 2, 32'h8000_0008));
        tv.push_back(mk(0, 32'h0, 1, 0, 1, 1, 1, 32'h8000_000C));
        tv.push_back(mk(0, 32'h0, 0, 0, 0, 1, 0, 0));
        // full with simultaneous pop, valid_in held
        tv.push_back(mk(1, 32'h8000_00A0, 0, 0, 0, 1, 0, 0));
        tv.push_back(mk(1, 32'h8000_00A4, 0, 0, 1, 1, 1, 32'h8000_00A0));
        tv.push_back(mk(1, 32'h8000_00A8, 0, 0, 1, 1, 2, 32'h8000_00A0));
        tv.push_back(mk(1, 32'h8000_00AC, 0, 0, 1, 1, 3, 32'h8000_00A0));
        tv.push_back(mk(1, 32'h8000_00B0, 1, 0, 1, 0, 4, 32'h8000_00A0));
        tv.push_back(mk(1, 32'h8000_00B0, 0, 0, 1, 1, 3, 32'h8000_00A4));
        tv.push_back(mk(0, 32'h0, 0, 0, 1, 0, 4, 32'h8000_00A4));
        tv.push_back(mk(0, 32'h0, 1, 0, 1, 0, 4, 32'h8000_00A4));
        tv.push_back(mk(0, 32'h0, 1, 0, 1, 1, 3, 32'h8000_00A8));
        tv.push_back(mk(0, 32'h0, 1, 0, 1, 1, 2, 32'h8000_00AC));
        tv.push_back(mk(0, 32'h0, 1, 0, 1, 1, 1, 32'h8000_00B0));
        tv.push_back(mk(0, 32'h0, 0, 0, 0, 1, 0, 0));
        // flush with three queued and valid_in high
        tv.push_back(mk(1, 32'h8000_00C0, 0, 0, 0, 1, 0, 0));
        tv.push_back(mk(1, 32'h8000_00C4, 0, 0, 1, 1, 1, 32'h8000_00C0));
        tv.push_back(mk(1, 32'h8000_00C8, 0, 0, 1, 1, 2, 32'h8000_00C0));
        tv.push_back(mk(1, 32'h8000_00CC, 0, 1, 0, 1, 3, 0));
        tv.push_back(mk(1, 32'h8000_0200, 0, 0, 0, 1, 0, 0));
        tv.push_back(mk(0, 32'h0, 1, 0, 1, 1, 1, 32'h8000_0200));
        tv.push_back(mk(0, 32'h0, 0, 0, 0, 1, 0, 0));

        #1;
        chk("por d0 vo", 64'(b0.valid_out), 64'd0);
        chk("por d0 ri", 64'(b0.ready_in), 64'd1);
        do_reset();

        foreach (tv[i]) begin
            v = tv[i].v; pc = tv[i].pc; ro = tv[i].ro; fl = tv[i].fl;
            inst = 32'h0000_0013; bp = tv[i].pc[2];
            #2;
            chk($sformatf("vec%0d vo", i), 64'(b0.valid_out), 64'(tv[i].vo));
            chk($sformatf("vec%0d ri", i), 64'(b0.ready_in), 64'(tv[i].ri));
            chk($sformatf("vec%0d cnt", i), 64'(b0.o_count), 64'(tv[i].cnt));
            chk($sformatf("vec%0d empty", i), 64'(b0.o_empty),
                64'(tv[i].cnt == 0));
            chk($sformatf("vec%0d full", i), 64'(b0.o_full),
                64'(tv[i].cnt == DEPTH));
            if (tv[i].vo) begin
                chk($sformatf("vec%0d pc", i), 64'(b0.o_pc), 64'(tv[i].opc));
                chk($sformatf("vec%0d inst", i), 64'(b0.o_inst),
                    64'h13);
                chk($sformatf("vec%0d bp", i), 64'(b0.o_branch_predict),
                    64'(tv[i].opc[2]));
            end
            next_cycle();
        end

        // bypass on dut1
        do_reset();
        v = 1; pc = 32'h8000_0100; inst = 32'h0000_0013; ro = 1; #2;
        chk("byp vo", 64'(b1.valid_out), 64'd1);
        chk("byp pc", 64'(b1.o_pc), 64'h8000_0100);
        chk("byp cnt", 64'(b1.o_count), 64'd0);
        next_cycle();
        v = 1; pc = 32'h8000_0104; ro = 0; #2;
        chk("byp2 cnt0", 64'(b1.o_count), 64'd0);
        chk("byp2 pc", 64'(b1.o_pc), 64'h8000_0104);
        chk("byp2 vo", 64'(b1.valid_out), 64'd1);
        next_cycle();
        v = 0; pc = 32'h0; #2;
        chk("byp3 cnt", 64'(b1.o_count), 64'd1);
        chk("byp3 pc", 64'(b1.o_pc), 64'h8000_0104);
        chk("byp3 vo", 64'(b1.valid_out), 64'd1);
        next_cycle();

        // async reset between edges with two entries held
        do_reset();
        v = 1; pc = 32'h8000_0300; next_cycle();
        pc = 32'h8000_0304; next_cycle();
        v = 0; #2;
        chk("arst pre cnt", 64'(b0.o_count), 64'd2);
        #1 rst = 1'b1;
        #1;
        chk("arst cnt", 64'(b0.o_count), 64'd0);
        chk("arst vo", 64'(b0.valid_out), 64'd0);
        chk("arst ri", 64'(b0.ready_in), 64'd1);
        chk("arst d1 cnt", 64'(b1.o_count), 64'd0);
        next_cycle();
        rst = 1'b0;
        v = 1; pc = 32'h8000_0310; #2;
        chk("arst resume vo0", 64'(b0.valid_out), 64'd0);
        next_cycle();
        v = 0; #2;
        chk("arst resume cnt", 64'(b0.o_count), 64'd1);
        chk("arst resume pc", 64'(b0.o_pc), 64'h8000_0310);
        next_cycle();

        // random traffic against the queue model
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            v    = ($urandom_range(0, 9) < 7);
            ro   = ($urandom_range(0, 9) < (c < 750 ? 3 : 8));
            fl   = ($urandom_range(0, 24) == 0);
            pc   = $urandom;
            inst = $urandom;
            bp   = $urandom_range(0, 1);
            #2;
            rstep(0, c);
            rstep(1, c);
            next_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
